softmax_grad: RTL and testbench
===============================

Name: softmax_grad

Overview:
- Backward-direction companion to the softmax stage of the CNN classifier head.
- Consumes the per-class probability vector one element per transfer, together with the ground-truth label captured at start.
- Emits the cross-entropy gradient w.r.t. logits, p_i - y_i, as a stream for the preceding layer's weight update.
- Tracks the argmax class and reports the prediction and a correct/incorrect flag at end of vector.

Parameters:
- BIT_REP, 8: width of an input probability; unsigned fraction, ONE = 2^BIT_REP - 1 represents 1.0.
- IN_LENGTH, 10: number of classes per vector (>= 2).
- IDX_W, $clog2(IN_LENGTH): class-index width.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: asynchronous active-high reset.
- start, input, 1: begin a vector; honoured only in IDLE.
- label, input, IDX_W: ground-truth class, sampled when start is honoured.
- label_err, output, 1: one-cycle pulse when start arrives in IDLE with label >= IN_LENGTH.
- busy, output, 1: high in STREAM and DONE.
- in_valid, input, 1: probability element valid.
- in_ready, output, 1: element accepted when in_valid && in_ready.
- in_prob, input, BIT_REP: probability of the current class, in class order 0..IN_LENGTH-1.
- out_valid, output, 1: gradient element valid.
- out_ready, input, 1: downstream accept.
- out_grad, output, BIT_REP+1: signed two's-complement p_i - y_i.
- out_idx, output, IDX_W: class index of out_grad.
- out_last, output, 1: high with the element for class IN_LENGTH-1.
- done, output, 1: one-cycle pulse when the vector completes.
- pred_class, output, IDX_W: argmax class, valid from done until next honoured start.
- correct, output, 1: pred_class == captured label, same validity as pred_class.

Behaviour:
- Reset (async, any state): state IDLE; counter 0; all outputs 0, including in_ready, out_valid, pred_class, correct and the stored label.
- States: IDLE, STREAM, DONE.
- IDLE:
  - in_ready = 0.
  - start with label < IN_LENGTH: capture label, clear counter and argmax, go to STREAM next cycle.
  - start with label >= IN_LENGTH: stay in IDLE, pulse label_err.
  - start while busy is ignored, with no label_err.
- STREAM, input side:
  - in_ready = !out_valid || out_ready (single output register, no bubble under continuous flow).
  - Accepted element i: on the next edge out_valid = 1, out_idx = i, out_last = (i == IN_LENGTH-1).
  - out_grad = {1'b0, in_prob} - (i == label ? ONE : 0), sign-extended to BIT_REP+1; no saturation needed.
- STREAM, output side:
  - Latency in-accept to out_valid is 1 cycle.
  - out_* hold stable while out_valid && !out_ready.
  - out_valid drops after a transfer with no new accept.
- Argmax:
  - Element 0 initialises max.
  - Later element replaces max only if strictly greater; ties keep the lower index.
- Counter: increments per accept. After the accept of element IN_LENGTH-1, in_ready = 0 until the next vector.
- STREAM -> DONE: on the cycle the out_last element transfers (out_valid && out_ready && out_last).
- DONE (1 cycle): done = 1; pred_class and correct update on entry to DONE; then go to IDLE.
- pred_class and correct hold until the next honoured start, which clears them to 0.
- Elements presented while in IDLE or DONE are not accepted.

Test Plan:
- Reset mid-STREAM after 4 accepts -> next cycle all outputs 0, state IDLE; a fresh start then processes a full 10-element vector.
- IN_LENGTH=10, label=3, probs {10,20,30,200,5,0,0,0,0,0}, out_ready=1 -> grads {10,20,30,-55,5,0,0,0,0,0}; out_last on idx 9; done one cycle after the last transfer; pred_class=3, correct=1.
- label=0, probs all 25 except idx 7 = 25 (tie) -> pred_class=0; grad[0]=-230; correct=1.
- label=9, probs max at idx 2 = 180 -> pred_class=2, correct=0, grad[9]=p9-255.
- out_ready toggles 1,0,0,1 with in_valid held -> no element dropped or duplicated; out_grad stable while stalled; in_ready low during stall.
- start with label=12 in IDLE -> label_err pulses once, busy stays 0. start while busy with label=5 -> ignored, stored label unchanged.

Source files
------------

// File: rtl/softmax_grad.sv
// Cross-entropy gradient stream (p_i - y_i) for one softmax probability vector,
// with argmax tracking and a prediction/correct report when the vector ends.
module softmax_grad #(
   parameter int BIT_REP   = 8,
   parameter int IN_LENGTH = 10,
   parameter int IDX_W     = $clog2(IN_LENGTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [IDX_W-1:0]   label,
   output logic               label_err,
   output logic               busy,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [BIT_REP-1:0] in_prob,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [BIT_REP:0]   out_grad,
   output logic [IDX_W-1:0]   out_idx,
   output logic               out_last,
   output logic               done,
   output logic [IDX_W-1:0]   pred_class,
   output logic               correct,
   output logic [1:0]         dbg_state
);

   // Handshake: a beat moves on a rising edge where valid && ready. A producer
   // never withdraws valid or changes its payload until that beat has moved.

   localparam int CNT_W = $clog2(IN_LENGTH + 1);
   localparam logic [CNT_W-1:0] LEN_C  = CNT_W'(IN_LENGTH);
   localparam logic [CNT_W-1:0] LAST_C = CNT_W'(IN_LENGTH - 1);
   localparam logic [IDX_W:0]   LEN_L  = (IDX_W + 1)'(IN_LENGTH);
   localparam logic [BIT_REP:0] ONE_E  = {1'b0, {BIT_REP{1'b1}}};

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_STREAM = 2'd1,
      S_DONE   = 2'd2
   } state_e;

   state_e state_q, state_d;

   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [IDX_W-1:0]   label_q, label_d;
   logic [BIT_REP-1:0] max_val_q, max_val_d;
   logic [IDX_W-1:0]   max_idx_q, max_idx_d;
   logic [IDX_W-1:0]   pred_q, pred_d;
   logic               correct_q, correct_d;
   logic               label_err_q, label_err_d;
   logic               out_valid_q, out_valid_d;
   logic [BIT_REP:0]   out_grad_q, out_grad_d;
   logic [IDX_W-1:0]   out_idx_q, out_idx_d;
   logic               out_last_q, out_last_d;

   logic               label_in_range;
   logic               start_ok;
   logic               in_fire;
   logic               out_fire;
   logic               last_fire;
   logic [IDX_W-1:0]   cur_idx;
   logic [BIT_REP:0]   grad;

   assign label_in_range = ({1'b0, label} < LEN_L);
   assign start_ok       = (state_q == S_IDLE) && start && label_in_range;
   assign in_fire        = in_valid && in_ready;
   assign out_fire       = out_valid_q && out_ready;
   assign last_fire      = out_fire && out_last_q;
   assign cur_idx        = cnt_q[IDX_W-1:0];
   // Subtracting ONE only on the labelled class gives p_i - y_i with no overflow.
   assign grad           = {1'b0, in_prob} - ((cur_idx == label_q) ? ONE_E : '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (start_ok) state_d = S_STREAM;
         S_STREAM: if (last_fire) state_d = S_DONE;
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == S_STREAM) && (cnt_q < LEN_C) && (!out_valid_q || out_ready);
      busy      = (state_q != S_IDLE);
      done      = (state_q == S_DONE);
      dbg_state = state_q;
   end

   always_comb begin
      cnt_d       = cnt_q;
      label_d     = label_q;
      max_val_d   = max_val_q;
      max_idx_d   = max_idx_q;
      pred_d      = pred_q;
      correct_d   = correct_q;
      label_err_d = (state_q == S_IDLE) && start && !label_in_range;
      out_valid_d = out_valid_q;
      out_grad_d  = out_grad_q;
      out_idx_d   = out_idx_q;
      out_last_d  = out_last_q;

      if (start_ok) begin
         label_d   = label;
         cnt_d     = '0;
         max_val_d = '0;
         max_idx_d = '0;
         pred_d    = '0;
         correct_d = 1'b0;
      end

      if (in_fire) begin
         cnt_d       = cnt_q + CNT_W'(1);
         out_valid_d = 1'b1;
         out_grad_d  = grad;
         out_idx_d   = cur_idx;
         out_last_d  = (cnt_q == LAST_C);
         // Strictly-greater update keeps the lowest index on ties.
         if ((cnt_q == '0) || (in_prob > max_val_q)) begin
            max_val_d = in_prob;
            max_idx_d = cur_idx;
         end
      end else if (out_fire) begin
         out_valid_d = 1'b0;
      end

      if (last_fire) begin
         pred_d    = max_idx_q;
         correct_d = (max_idx_q == label_q);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q       <= '0;
         label_q     <= '0;
         max_val_q   <= '0;
         max_idx_q   <= '0;
         pred_q      <= '0;
         correct_q   <= 1'b0;
         label_err_q <= 1'b0;
         out_valid_q <= 1'b0;
         out_grad_q  <= '0;
         out_idx_q   <= '0;
         out_last_q  <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         label_q     <= label_d;
         max_val_q   <= max_val_d;
         max_idx_q   <= max_idx_d;
         pred_q      <= pred_d;
         correct_q   <= correct_d;
         label_err_q <= label_err_d;
         out_valid_q <= out_valid_d;
         out_grad_q  <= out_grad_d;
         out_idx_q   <= out_idx_d;
         out_last_q  <= out_last_d;
      end
   end

   assign label_err  = label_err_q;
   assign out_valid  = out_valid_q;
   assign out_grad   = out_grad_q;
   assign out_idx    = out_idx_q;
   assign out_last   = out_last_q;
   assign pred_class = pred_q;
   assign correct    = correct_q;

endmodule

// File: tb/tb_softmax_grad.sv
// Bench for softmax_grad: scenario tasks checked against a behavioural model
// of the gradient/argmax rules, with randomized valid/ready pacing.
module tb_softmax_grad;

   localparam int W  = 8;
   localparam int N  = 10;
   localparam int IW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [IW-1:0] label = '0;
   logic          label_err;
   logic          busy;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_prob = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W:0]    out_grad;
   logic [IW-1:0] out_idx;
   logic          out_last;
   logic          done;
   logic [IW-1:0] pred_class;
   logic          correct;
   logic [1:0]    dbg_state;

   int checks = 0;
   int errors = 0;
   int vec[N];
   logic [W:0] exp_q[$];

   softmax_grad #(.BIT_REP(W), .IN_LENGTH(N)) dut (
      .clk(clk), .rst(rst), .start(start), .label(label), .label_err(label_err),
      .busy(busy), .in_valid(in_valid), .in_ready(in_ready), .in_prob(in_prob),
      .out_valid(out_valid), .out_ready(out_ready), .out_grad(out_grad),
      .out_idx(out_idx), .out_last(out_last), .done(done), .pred_class(pred_class),
      .correct(correct), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check_all_zero(input string tag);
      logic [31:0] agg;
      agg = {16'(out_grad), 4'(out_idx), 4'(pred_class), dbg_state, out_valid, in_ready,
             busy, done, label_err, out_last, correct, 1'b0};
      checks++;
      if (agg !== 32'd0) begin
         errors++;
         $display("FAIL %s: outputs packed=%h required=0", tag, agg);
      end
   endtask

   task automatic do_start(input int lbl);
      @(negedge clk);
      start = 1'b1;
      label = IW'(lbl);
      @(negedge clk);
      start = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b1 || pred_class !== '0 || correct !== 1'b0 || label_err !== 1'b0) begin
         errors++;
         $display("FAIL start_accept: busy=%b pred=%0d correct=%b label_err=%b required 1/0/0/0",
                  busy, pred_class, correct, label_err);
      end
   endtask

   // Feeds vec[] under the given pacing and checks every output beat plus the report.
   task automatic run_vector(input int lbl, input int rdy_mode, input int vld_mode);
      int exp_pred, maxv, send, got, iter, last_iter, done_iter;
      logic exp_corr, stalled, found;
      logic [W:0] held_grad, e;
      logic [IW-1:0] held_idx;
      exp_q.delete();
      maxv = -1;
      for (int i = 0; i < N; i++) begin
         exp_q.push_back((W+1)'(vec[i] - ((i == lbl) ? 255 : 0)));
         if (vec[i] > maxv) maxv = vec[i];
      end
      exp_pred = 0;
      found = 1'b0;
      for (int i = 0; i < N; i++)
         if (!found && vec[i] == maxv) begin exp_pred = i; found = 1'b1; end
      exp_corr = (exp_pred == lbl);
      send = 0; got = 0; iter = 0; last_iter = -1; done_iter = -1;
      stalled = 1'b0; held_grad = '0; held_idx = '0;
      while (done_iter < 0 && iter < 400) begin
         @(negedge clk);
         start = 1'b0;
         if (send < N) begin
            in_valid = (vld_mode == 0) || ($urandom_range(0, 3) != 0);
            in_prob  = W'(vec[send]);
         end else begin
            in_valid = 1'($urandom_range(0, 1));
            in_prob  = W'($urandom_range(0, 255));
         end
         case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = (iter % 4 == 0) || (iter % 4 == 3);
         endcase
         #1;
         if (stalled) begin
            checks++;
            if (out_valid !== 1'b1 || out_grad !== held_grad || out_idx !== held_idx) begin
               errors++;
               $display("FAIL stall_hold: valid=%b grad=%0d idx=%0d required 1/%0d/%0d",
                        out_valid, $signed(out_grad), out_idx, $signed(held_grad), held_idx);
            end
         end
         if (out_valid && !out_ready) begin
            checks++;
            if (in_ready !== 1'b0) begin
               errors++;
               $display("FAIL stall_in_ready: in_ready=%b required 0", in_ready);
            end
         end
         if (send == N) begin
            checks++;
            if (in_ready !== 1'b0) begin
               errors++;
               $display("FAIL in_ready_after_last: in_ready=%b required 0", in_ready);
            end
         end
         if (done === 1'b1) done_iter = iter;
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL extra_beat: idx=%0d grad=%0d required no beat", out_idx, $signed(out_grad));
            end else begin
               e = exp_q.pop_front();
               if (out_grad !== e || out_idx !== IW'(got) || out_last !== (got == N - 1)) begin
                  errors++;
                  $display("FAIL grad_beat: grad=%0d idx=%0d last=%b required %0d/%0d/%b",
                           $signed(out_grad), out_idx, out_last, $signed(e), got, (got == N - 1));
               end
               got++;
               if (got == N) last_iter = iter;
            end
         end
         if (in_valid && in_ready) send++;
         stalled   = out_valid && !out_ready;
         held_grad = out_grad;
         held_idx  = out_idx;
         iter++;
      end
      checks++;
      if (done_iter < 0) begin
         errors++;
         $display("FAIL done_timeout: no done after %0d cycles, beats=%0d required %0d", iter, got, N);
      end else if (done_iter != last_iter + 1 || got != N) begin
         errors++;
         $display("FAIL done_timing: done_cycle=%0d beats=%0d required %0d/%0d",
                  done_iter, got, last_iter + 1, N);
      end
      checks++;
      if (pred_class !== IW'(exp_pred) || correct !== exp_corr) begin
         errors++;
         $display("FAIL prediction: pred=%0d correct=%b required %0d/%b",
                  pred_class, correct, exp_pred, exp_corr);
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || pred_class !== IW'(exp_pred) || correct !== exp_corr) begin
         errors++;
         $display("FAIL post_done: done=%b busy=%b pred=%0d correct=%b required 0/0/%0d/%b",
                  done, busy, pred_class, correct, exp_pred, exp_corr);
      end
   endtask

   task automatic test_reset;
      int acc;
      repeat (3) @(negedge clk);
      #1;
      check_all_zero("reset_initial");
      @(negedge clk);
      rst = 1'b0;
      do_start(3);
      acc = 0;
      for (int c = 0; c < 40 && acc < 4; c++) begin
         @(negedge clk);
         in_valid  = 1'b1;
         in_prob   = W'($urandom_range(0, 255));
         out_ready = 1'b1;
         #1;
         if (in_ready) acc++;
      end
      @(posedge clk);
      #2;
      checks++;
      if (acc != 4 || busy !== 1'b1) begin
         errors++;
         $display("FAIL reset_setup: accepts=%0d busy=%b required 4/1", acc, busy);
      end
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      #1;
      check_all_zero("reset_async");
      @(negedge clk);
      #1;
      check_all_zero("reset_held");
      rst = 1'b0;
      for (int i = 0; i < N; i++) vec[i] = $urandom_range(0, 255);
      do_start(6);
      run_vector(6, 0, 0);
   endtask

   task automatic test_fixed_vectors;
      vec = '{10, 20, 30, 200, 5, 0, 0, 0, 0, 0};
      do_start(3);
      run_vector(3, 0, 0);
      for (int i = 0; i < N; i++) vec[i] = 25;
      do_start(0);
      run_vector(0, 0, 0);
      for (int i = 0; i < N; i++) vec[i] = $urandom_range(0, 179);
      vec[2] = 180;
      do_start(9);
      run_vector(9, 0, 0);
   endtask

   task automatic test_backpressure;
      for (int i = 0; i < N; i++) vec[i] = $urandom_range(0, 255);
      do_start(4);
      run_vector(4, 2, 0);
   endtask

   task automatic test_label_err;
      @(negedge clk);
      start = 1'b1;
      label = IW'(12);
      @(negedge clk);
      start = 1'b0;
      #1;
      checks++;
      if (label_err !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL label_err_pulse: label_err=%b busy=%b required 1/0", label_err, busy);
      end
      @(negedge clk);
      #1;
      checks++;
      if (label_err !== 1'b0 || busy !== 1'b0 || dbg_state !== 2'd0) begin
         errors++;
         $display("FAIL label_err_after: label_err=%b busy=%b state=%0d required 0/0/0",
                  label_err, busy, dbg_state);
      end
   endtask

   task automatic test_start_while_busy;
      for (int i = 0; i < N; i++) vec[i] = $urandom_range(0, 255);
      do_start(3);
      start = 1'b1;
      label = IW'(5);
      @(negedge clk);
      start = 1'b0;
      #1;
      checks++;
      if (label_err !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL start_busy: label_err=%b busy=%b required 0/1", label_err, busy);
      end
      run_vector(3, 0, 0);
   endtask

   task automatic test_random;
      int lbl;
      for (int v = 0; v < 8; v++) begin
         for (int i = 0; i < N; i++)
            vec[i] = (v % 2 == 0) ? $urandom_range(0, 255) : 60 * $urandom_range(0, 4);
         lbl = $urandom_range(0, N - 1);
         do_start(lbl);
         run_vector(lbl, 1, 1);
      end
   endtask

   initial begin
      test_reset();
      test_fixed_vectors();
      test_backpressure();
      test_label_err();
      test_start_while_busy();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
